// File: rtl/sram_controller.sv
// sram_controller: splits 32-bit loads/stores into two 16-bit SRAM half-word accesses plus settle cycles
module sram_controller #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, ACC_LO, ACC_HI, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic op_wr, req, acc, drive;
  logic [16:0] word_q, off;
  logic [31:0] data_q;
  logic [15:0] dq_out;
  logic unused_addr;
  // Only address bits 18:2 survive the word mapping; the rest wrap away.
  assign unused_addr = ^{address[31:19], address[1:0]};
  assign req = rd_en | wr_en;
  assign off = word_q - 17'd256;
  assign SRAM_DQ = drive ? dq_out : 16'hzzzz;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      op_wr <= 1'b0;
      word_q <= '0;
      data_q <= '0;
      read_data <= '0;
    end else begin
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      if (state == IDLE && req) begin
        op_wr <= wr_en;
        word_q <= address[18:2];
        data_q <= write_data;
      end
      if (!op_wr && state == ACC_LO) read_data[15:0] <= SRAM_DQ;
      if (!op_wr && state == ACC_HI) read_data[31:16] <= SRAM_DQ;
    end
  end
  always_comb begin
    state_n = state == IDLE   ? (req ? ACC_LO : IDLE) :
              state == ACC_LO ? ACC_HI :
              state == ACC_HI ? WAIT :
              state == WAIT   ? (cnt == CW'(WAIT_CYCLES - 1) ? DONE : WAIT) :
              IDLE;
  end
  always_comb begin
    acc = (state == ACC_LO) || (state == ACC_HI);
    drive = op_wr && acc;
    ready = (state == DONE) || (state == IDLE && !req);
    SRAM_WE_N = !drive;
    SRAM_ADDR = acc ? {off, state == ACC_HI} : '0;
    dq_out = (state == ACC_HI) ? data_q[31:16] : data_q[15:0];
  end
endmodule
